hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised stall/forward controller for the decode stage; replaces per-stage address compares.
//  Tracks every in-flight GPR write in a per-register scoreboard:
//   - pending flag
//   - remaining-Tnew countdown
//   - producing stage (E/M/W)
//  Per read port it generates the stall request and the bypass select.
//  Also owns the mult/div busy countdown and the post-mtc0-EPC eret hold-off counter.
// PARAMETERS
//  NREG      32  architectural registers (reg 0 never tracked)
//  AW        5   register address width
//  TW        3   Tnew/Tuse width
//  NRP       2   read ports checked per cycle
//  MULT_LAT  5   cycles HI/LO busy after a mult start
//  DIV_LAT   10  cycles HI/LO busy after a div start
//  CP0_WAIT  2   cycles eret is held after mtc0 to EPC
// PORTS
//  clk             in  1        clock, rising edge
//  reset           in  1        asynchronous, active-high
//  issue_valid     in  1        ID instruction would advance to E this cycle
//  issue_waddr     in  AW       destination register (0 = no write)
//  issue_tnew      in  TW       cycles until result exists, counted from E entry
//  issue_md_start  in  1        instruction starts mult/div
//  issue_md_div    in  1        1 = div latency, 0 = mult latency
//  issue_mtc0_epc  in  1        instruction is mtc0 to EPC (cp0 reg 14)
//  rd_addr         in  NRP*AW   source register per port
//  rd_tuse         in  NRP*TW   Tuse per port
//  rd_uses_hilo    in  1        ID instruction reads or writes HI/LO
//  rd_is_eret      in  1        ID instruction is eret
//  flush           in  1        exception: kill E and M occupants
//  stall           out 1        freeze PC/IF-ID, bubble into E
//  fwd_sel         out NRP*2    per port: 0 GRF, 1 E, 2 M, 3 W
//  md_busy         out 1        HI/LO unit busy
// BEHAVIOUR
//  Reset (async): all entries cleared, md/eret counters = 0; stall = 0, fwd_sel = 0, md_busy = 0.
//  Issue qualification: accept = issue_valid & ~stall & ~flush. On accept with waddr != 0:
//   - entry[waddr] <= pending, tnew = issue_tnew, stage = E.
//   - Issue overwrites any older entry for the same reg; younger writer wins.
//  Every clock, for each pending entry not written by accept:
//   - tnew <= sat0(tnew-1)
//   - stage advances E -> M -> W; the W entry clears on the next edge.
//  Same reg, same cycle, issue vs clear/advance: issue wins.
//  flush: pending entries in E or M cleared; W entries still advance. Counters cleared, no accept.
//  Per port p (combinational from registered state), with a = rd_addr[p] and e = entry[a]:
//   - a == 0 or e not pending: fwd_sel = 0, no hazard.
//   - e.tnew > rd_tuse[p]: hazard (stall contributor); fwd_sel = 0.
//   - otherwise: fwd_sel = e.stage (1/2/3).
//  md counter:
//   - on accept & issue_md_start, load DIV_LAT or MULT_LAT; else decrement, saturating at 0.
//   - md_busy = (cnt != 0).
//  eret counter: on accept & issue_mtc0_epc load CP0_WAIT; else decrement, saturating at 0.
//  stall = OR(port hazards) | (rd_uses_hilo & md_busy) | (rd_is_eret & eret_cnt != 0).
//  Latency:
//   - scoreboard updates visible to the port checks the cycle after accept.
//   - stall and fwd_sel are same-cycle combinational outputs.
//  Reset mid-stall drops all state; nothing replays.
// STRUCTURE
//  Shared package holds:
//   - FWD_GRF/FWD_E/FWD_M/FWD_W encodings
//   - STG_E/STG_M/STG_W codes
//   - scoreboard entry struct {pending, tnew, stage}
//  Sub-module hazard_sb_entry: one entry (pending/tnew/stage registers, advance, flush); generate NREG-1 copies.
//  Port checks, counters and stall OR-reduce live in the top module.
// TESTING
//  - lw $1 (tnew 2) accepted, next cycle addu reads $1 with tuse 1 -> stall=1 for one cycle; following cycle fwd_sel=2.
//  - addu $2 (tnew 1) accepted, next cycle beq on $2 with tuse 0 -> stall 1 cycle; then fwd_sel=2 (M), stall=0.
//  - Back-to-back writes to $3 (tnew 0): second overwrites, reader sees fwd_sel=1; $0 write -> fwd_sel=0.
//  - div start then mfhi: stall held exactly DIV_LAT=10 cycles; md_busy falls with it.
//  - mtc0 EPC then eret: stall 2 cycles, then released.
//  - flush with $4 in M and $5 in W: $4 fwd_sel=0 next cycle; $5 reads 3 and clears.
//  - reset asserted mid-stall: all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and encodings for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int unsigned SB_NREG = 32;
    localparam int unsigned SB_AW   = 5;
    localparam int unsigned SB_TW   = 3;
    localparam int unsigned SB_NRP  = 2;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    typedef enum logic [1:0] {
        STG_NONE = 2'd0,
        STG_E    = 2'd1,
        STG_M    = 2'd2,
        STG_W    = 2'd3
    } stage_e;

    typedef struct packed {
        logic               pending;
        logic [SB_TW-1:0]   tnew;
        stage_e             stage;
    } sb_entry_t;

    function automatic logic [1:0] stage_to_fwd(stage_e stage);
        case (stage)
            STG_E:   return FWD_E;
            STG_M:   return FWD_M;
            STG_W:   return FWD_W;
            default: return FWD_GRF;
        endcase
    endfunction

    // Counter width able to hold max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage <-> hazard scoreboard signal bundle.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NRP = SB_NRP,
    parameter int unsigned AW  = SB_AW,
    parameter int unsigned TW  = SB_TW
) ();

    logic               issue_valid;
    logic [AW-1:0]      issue_waddr;
    logic [TW-1:0]      issue_tnew;
    logic               issue_md_start;
    logic               issue_md_div;
    logic               issue_mtc0_epc;
    logic [NRP*AW-1:0]  rd_addr;
    logic [NRP*TW-1:0]  rd_tuse;
    logic               rd_uses_hilo;
    logic               rd_is_eret;
    logic               flush;
    logic               stall;
    logic [NRP*2-1:0]   fwd_sel;
    logic               md_busy;

    modport master (
        output issue_valid, issue_waddr, issue_tnew, issue_md_start, issue_md_div,
               issue_mtc0_epc, rd_addr, rd_tuse, rd_uses_hilo, rd_is_eret, flush,
        input  stall, fwd_sel, md_busy
    );

    modport slave (
        input  issue_valid, issue_waddr, issue_tnew, issue_md_start, issue_md_div,
               issue_mtc0_epc, rd_addr, rd_tuse, rd_uses_hilo, rd_is_eret, flush,
        output stall, fwd_sel, md_busy
    );

endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: pending flag, remaining Tnew and producing stage.
module hazard_sb_entry
    import hazard_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_write,
    input  logic [SB_TW-1:0] i_tnew,
    input  logic             i_flush,
    output sb_entry_t        o_entry
);

    sb_entry_t r_entry;

    // A fresh issue beats any advance/clear of the older writer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_entry <= '0;
        end else if (i_write) begin
            r_entry.pending <= 1'b1;
            r_entry.tnew    <= i_tnew;
            r_entry.stage   <= STG_E;
        end else if (r_entry.pending) begin
            if (i_flush || r_entry.stage == STG_W) begin
                r_entry <= '0;
            end else begin
                r_entry.tnew  <= (r_entry.tnew != '0) ? r_entry.tnew - SB_TW'(1) : '0;
                r_entry.stage <= (r_entry.stage == STG_E) ? STG_M : STG_W;
            end
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage stall/forward controller built on a per-register write scoreboard.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NREG     = SB_NREG,
    parameter int unsigned AW       = SB_AW,
    parameter int unsigned TW       = SB_TW,
    parameter int unsigned NRP      = SB_NRP,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CP0_WAIT = 2
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave bus
);

    localparam int unsigned MdMax = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int unsigned MdW   = cnt_width(MdMax);
    localparam int unsigned EretW = cnt_width(CP0_WAIT);

    sb_entry_t          w_entries [NREG];
    sb_entry_t          w_ent;
    logic [NRP-1:0]     w_port_hazard;
    logic [NRP*2-1:0]   w_fwd_sel;
    logic               w_stall;
    logic               w_accept;
    logic [MdW-1:0]     r_md_cnt;
    logic [EretW-1:0]   r_eret_cnt;

    assign w_accept    = bus.issue_valid & ~w_stall & ~bus.flush;
    assign w_entries[0] = '0;

    for (genvar g = 1; g < NREG; g++) begin : g_entry
        hazard_sb_entry u_entry (
            .clk     (clk),
            .reset   (reset),
            .i_write (w_accept && (bus.issue_waddr == AW'(g))),
            .i_tnew  (bus.issue_tnew),
            .i_flush (bus.flush),
            .o_entry (w_entries[g])
        );
    end

    // Register 0 maps to the always-empty entry, so it never hazards or forwards.
    always_comb begin
        w_port_hazard = '0;
        w_fwd_sel     = {NRP{FWD_GRF}};
        w_ent         = '0;
        for (int p = 0; p < NRP; p++) begin
            w_ent = w_entries[bus.rd_addr[p*AW +: AW]];
            if (w_ent.pending) begin
                if (w_ent.tnew > bus.rd_tuse[p*TW +: TW]) begin
                    w_port_hazard[p] = 1'b1;
                end else begin
                    w_fwd_sel[p*2 +: 2] = stage_to_fwd(w_ent.stage);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (bus.flush) begin
            r_md_cnt <= '0;
        end else if (w_accept && bus.issue_md_start) begin
            r_md_cnt <= bus.issue_md_div ? MdW'(DIV_LAT) : MdW'(MULT_LAT);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - MdW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_eret_cnt <= '0;
        end else if (bus.flush) begin
            r_eret_cnt <= '0;
        end else if (w_accept && bus.issue_mtc0_epc) begin
            r_eret_cnt <= EretW'(CP0_WAIT);
        end else if (r_eret_cnt != '0) begin
            r_eret_cnt <= r_eret_cnt - EretW'(1);
        end
    end

    assign w_stall = (|w_port_hazard)
                   | (bus.rd_uses_hilo & (r_md_cnt != '0))
                   | (bus.rd_is_eret & (r_eret_cnt != '0));

    assign bus.stall   = w_stall;
    assign bus.fwd_sel = w_fwd_sel;
    assign bus.md_busy = (r_md_cnt != '0);

endmodule
